// File: rtl/activation_backward.sv
// rtl/activation_backward.sv - backward gradient through sigmoid/tanh/binary/linear activations
module activation_backward #(
  parameter int DATA_W = 17,
  parameter int FRAC_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_mode,
  input  logic signed [DATA_W-1:0] in_act,
  input  logic signed [DATA_W-1:0] in_grad,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_grad,
  output logic                     out_sat
);

  // Magnitudes carry DATA_W-1 bits; a full product needs twice that.
  localparam int MW = DATA_W - 1;
  localparam int PW = 2 * MW;
  localparam int CW = $clog2(MW);
  localparam logic [CW-1:0]            LAST      = CW'(MW - 1);
  localparam logic [MW-1:0]            MAX_MAG   = '1;
  localparam logic [MW-1:0]            ONE_MAG   = MW'(1) << FRAC_W;
  localparam logic signed [DATA_W-1:0] ONE_S     = DATA_W'(1) << FRAC_W;
  localparam logic signed [DATA_W-1:0] NEG_ONE_S = -ONE_S;
  localparam logic signed [DATA_W-1:0] MIN_S     = {1'b1, {MW{1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL1, MUL2, DONE} state_t;

  state_t state, state_next;

  logic [1:0]               mode_q;
  logic signed [DATA_W-1:0] grad_q;
  logic [PW-1:0]            acc;
  logic [PW-1:0]            mcand;
  logic [MW-1:0]            mplier;
  logic [CW-1:0]            cnt;
  logic                     neg;

  logic signed [DATA_W-1:0] sig_a, tanh_a, d_direct;
  logic [MW-1:0]            mul1_a, mul1_b;
  logic [PW-1:0]            acc_next, prod_shift;
  logic                     prod_sat, step_last;
  logic [MW-1:0]            prod_mag, d_mul1;
  logic [DATA_W-1:0]        res_ext, res_signed;

  // The most negative word has no positive twin, so it maps to the largest magnitude.
  function automatic logic [MW-1:0] mag_of(input logic signed [DATA_W-1:0] x);
    logic [DATA_W-1:0] n;
    n = -x;
    if (x == MIN_S)
      mag_of = MAX_MAG;
    else if (x[DATA_W-1])
      mag_of = n[MW-1:0];
    else
      mag_of = x[MW-1:0];
  endfunction

  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);

  // Clamp the incoming activation and pick the operands of the first multiply.
  always_comb begin
    sig_a = in_act;
    if (in_act[DATA_W-1])
      sig_a = '0;
    else if (in_act > ONE_S)
      sig_a = ONE_S;
    tanh_a = in_act;
    if (in_act > ONE_S)
      tanh_a = ONE_S;
    else if (in_act < NEG_ONE_S)
      tanh_a = NEG_ONE_S;
    if (in_mode == 2'd0) begin
      mul1_a = sig_a[MW-1:0];
      mul1_b = ONE_MAG - sig_a[MW-1:0];
    end else begin
      mul1_a = mag_of(tanh_a);
      mul1_b = mag_of(tanh_a);
    end
    if (in_mode == 2'd2)
      d_direct = (mag_of(in_act) <= ONE_MAG) ? ONE_S : '0;
    else
      d_direct = in_act;
  end

  // One shift-add step, plus the scaled/saturated view used on the last step.
  always_comb begin
    acc_next   = acc + (mplier[0] ? mcand : '0);
    prod_shift = acc_next >> FRAC_W;
    prod_sat   = |prod_shift[PW-1:MW];
    prod_mag   = prod_sat ? MAX_MAG : prod_shift[MW-1:0];
    step_last  = (cnt == LAST);
    d_mul1     = (mode_q == 2'd1) ? (ONE_MAG - prod_mag) : prod_mag;
    res_ext    = {1'b0, prod_mag};
    res_signed = (neg && (prod_mag != '0)) ? -res_ext : res_ext;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = in_mode[1] ? MUL2 : MUL1;
      MUL1: if (step_last) state_next = MUL2;
      MUL2: if (step_last) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture on accept, iterate the multiplier, publish the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= '0;
      grad_q   <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      out_grad <= '0;
      out_sat  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mode_q  <= in_mode;
            grad_q  <= in_grad;
            out_sat <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            if (in_mode[1]) begin
              mcand  <= PW'(mag_of(in_grad));
              mplier <= mag_of(d_direct);
              neg    <= in_grad[DATA_W-1] ^ d_direct[DATA_W-1];
            end else begin
              mcand  <= PW'(mul1_a);
              mplier <= mul1_b;
              neg    <= 1'b0;
            end
          end
        end
        MUL1: begin
          if (step_last) begin
            acc     <= '0;
            cnt     <= '0;
            mcand   <= PW'(mag_of(grad_q));
            mplier  <= d_mul1;
            neg     <= grad_q[DATA_W-1];
            out_sat <= out_sat | prod_sat;
          end else begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
          end
        end
        MUL2: begin
          if (step_last) begin
            out_grad <= res_signed;
            out_sat  <= out_sat | prod_sat;
          end else begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_activation_backward.sv
// tb/tb_activation_backward.sv - directed self-checking bench for activation_backward
module tb_activation_backward;

  localparam int DATA_W = 17;
  localparam int FRAC_W = 8;

  logic                     clk;
  logic                     rst_n;
  logic                     in_valid;
  logic                     in_ready;
  logic [1:0]               in_mode;
  logic signed [DATA_W-1:0] in_act;
  logic signed [DATA_W-1:0] in_grad;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_grad;
  logic                     out_sat;

  int checks = 0;
  int errors = 0;

  activation_backward #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_act    (in_act),
    .in_grad   (in_grad),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_grad  (out_grad),
    .out_sat   (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one request, then scramble the inputs after the accept edge.
  task automatic start(input logic [1:0] m, input int a, input int g);
    @(negedge clk);
    check("in_ready_before_accept", int'(in_ready), 1);
    in_valid = 1'b1;
    in_mode  = m;
    in_act   = DATA_W'(a);
    in_grad  = DATA_W'(g);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_mode  = ~m;
    in_act   = 17'h0AAAA;
    in_grad  = 17'h15555;
  endtask

  // Edges counted from the accept edge until out_valid is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic finish_txn(input string tag, input int exp_g, input int exp_s, input int exp_lat);
    int lat;
    wait_done(lat);
    check({tag, "_latency"}, lat, exp_lat);
    @(negedge clk);
    check({tag, "_grad"}, int'(out_grad), exp_g);
    check({tag, "_sat"}, int'(out_sat), exp_s);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_valid_clear"}, int'(out_valid), 0);
    check({tag, "_in_ready_back"}, int'(in_ready), 1);
  endtask

  initial begin
    int lat;
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 2'd0;
    in_act    = '0;
    in_grad   = '0;
    out_ready = 1'b0;

    #12;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_grad", int'(out_grad), 0);
    check("rst_out_sat", int'(out_sat), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sigmoid: d = 128*128/256 = 64, out = 256*64/256 = 64.
    start(2'd0, 128, 256);
    finish_txn("sig_128", 64, 0, 32);

    // Tanh: d = 256 - 64 = 192, out = 512*192/256 = 384.
    start(2'd1, 128, 512);
    finish_txn("tanh_128", 384, 0, 32);
    start(2'd1, -256, 300);
    finish_txn("tanh_m256", 0, 0, 32);
    start(2'd1, 1000, 300);
    finish_txn("tanh_clamp", 0, 0, 32);

    // Binary straight-through.
    start(2'd2, 768, 200);
    finish_txn("bin_out", 0, 0, 16);
    start(2'd2, 128, -200);
    finish_txn("bin_in", -200, 0, 16);

    // Linear: 32768*512/256 = 65536 saturates to -65535; then sat clears.
    start(2'd3, 512, -32768);
    finish_txn("lin_sat", -65535, 1, 16);
    start(2'd3, 256, 5);
    finish_txn("lin_5", 5, 0, 16);

    // Backpressure: hold DONE for 10 cycles while a new request is offered.
    start(2'd0, 128, 256);
    wait_done(lat);
    check("bp_latency", lat, 32);
    @(negedge clk);
    in_valid = 1'b1;
    in_mode  = 2'd3;
    in_act   = DATA_W'(256);
    in_grad  = DATA_W'(77);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid_hold", int'(out_valid), 1);
      check("bp_grad_hold", int'(out_grad), 64);
      check("bp_in_ready_low", int'(in_ready), 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_valid_clear", int'(out_valid), 0);
    check("bp_in_ready_back", int'(in_ready), 1);
    start(2'd3, 256, 5);
    finish_txn("bp_after", 5, 0, 16);

    // Asynchronous reset in the middle of MUL1.
    start(2'd0, 128, 256);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_out_grad", int'(out_grad), 0);
    check("mid_rst_out_sat", int'(out_sat), 0);
    check("mid_rst_in_ready", int'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", int'(in_ready), 1);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("post_rst_no_result", seen, 0);
    start(2'd0, 128, 256);
    finish_txn("post_rst_sig", 64, 0, 32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/activation_backward.md
Name: activation_backward

Overview:
- Backward-pass counterpart of the gdo forward operators (sigmoid, tanh, binary, linear).
- Takes a stored forward activation and an upstream gradient, and returns the gradient times the local activation derivative.
- Fixed-point format is signed, DATA_W wide, FRAC_W fractional bits (one = 2**FRAC_W).
- Sits between the layer's activation store and the weight-update logic. Uses one iterative shift-add multiplier under a valid/ready handshake on both sides.

Parameters:
- DATA_W, 17, total signed width of activation and gradient words.
- FRAC_W, 8, number of fractional bits; one = 2**FRAC_W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_mode  input  2  0 = sigmoid, 1 = tanh, 2 = binary (straight-through), 3 = linear.
- in_act  input  DATA_W  forward activation a, signed.
- in_grad  input  DATA_W  upstream gradient g, signed.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_grad  output  DATA_W  g * f'(a), signed.
- out_sat  output  1  the result was saturated.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; out_valid = 0, out_grad = 0, out_sat = 0.
  - in_ready is forced to 0 while rst_n is low.
  - Reset mid-operation aborts the request and returns no result.
- in_ready = (state == IDLE) when out of reset.
- Accept: on an edge with in_valid & in_ready, capture mode, a and g. Later input changes are ignored.
- States: IDLE, MUL1, MUL2, DONE.
- Derivative term d:
  - sigmoid: clamp a to [0, one]; MUL1 computes a*(one - a).
  - tanh: clamp a to [-one, one]; MUL1 computes a*a; then d = one - (a*a).
  - binary: d = one if |a| <= one, else 0. No MUL1.
  - linear: d = a, unclamped. No MUL1.
- MUL2 computes the final product g*d.
- Multiply rule, shared by MUL1 and MUL2:
  - Sign-magnitude.
  - One shift-add iteration per clock, DATA_W-1 iterations per product.
  - Magnitude product is shifted right by FRAC_W, which truncates toward zero.
  - Result sign = XOR of operand signs. A zero magnitude always gives +0.
  - If the shifted magnitude exceeds 2**(DATA_W-1)-1, it saturates to ±(2**(DATA_W-1)-1) and out_sat is set. -2**(DATA_W-1) is never produced.
  - An operand of -2**(DATA_W-1) uses magnitude 2**(DATA_W-1)-1.
- Transitions (accept edge = edge 0):
  - IDLE -> MUL1 for modes 0/1.
  - IDLE -> MUL2 for modes 2/3, with d already set.
  - MUL1 -> MUL2 after DATA_W-1 edges.
  - MUL2 -> DONE after DATA_W-1 edges.
- Latency (DATA_W = 17):
  - out_valid goes high after edge 32 for sigmoid/tanh.
  - out_valid goes high after edge 16 for binary/linear.
- DONE:
  - out_valid = 1; out_grad and out_sat are held stable until out_ready.
  - An edge with out_ready returns the state to IDLE and clears out_valid.
  - in_ready rises on the following cycle; there is no same-cycle bypass.
  - out_ready while not in DONE is ignored.
- out_sat is cleared on each new accept.

Test Plan:
1. Sigmoid, a = 128, g = 256 -> d = 64; out_grad = 64, out_sat = 0; out_valid asserted exactly 32 edges after accept.
2. Tanh, a = 128, g = 512 -> out_grad = 384. Tanh, a = -256, g = 300 -> out_grad = 0. Tanh, a = 1000 (clamped to one) -> out_grad = 0.
3. Binary, a = 768, g = 200 -> out_grad = 0. Binary, a = 128, g = -200 -> out_grad = -200; latency 16 edges.
4. Linear, a = 512, g = -32768 -> out_grad = -65535, out_sat = 1. Next request: linear, a = 256, g = 5 -> out_grad = 5, out_sat = 0.
5. Backpressure:
   - Hold out_ready = 0 for 10 cycles in DONE -> out_valid and out_grad stay stable, in_ready stays 0, and new in_valid is ignored.
   - Release out_ready -> IDLE, and in_ready returns 1 cycle later.
6. Reset mid-MUL1: drop rst_n asynchronously -> out_valid, out_grad and out_sat read 0 immediately, in_ready = 0. After release, in_ready = 1 and a fresh sigmoid request completes correctly.
